// File: rtl/zap_mult_pkg.sv
// Shared types and helpers for the zap_mult_seq multiply-accumulate unit.
package zap_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Widest result the flag helper can inspect; results are zero-extended into it.
    localparam int FLAG_MAX_W = 128;

    function automatic int limb_count(input int data_w, input int limb_w);
        return data_w / limb_w;
    endfunction

    // Returns {negative, zero} for the low `width` bits of value.
    function automatic logic [1:0] mult_flags(input logic [FLAG_MAX_W-1:0] value,
                                              input int width);
        logic zero;
        zero = 1'b1;
        for (int b = 0; b < FLAG_MAX_W; b++) begin
            if (b < width && value[b]) zero = 1'b0;
        end
        return {value[width-1], zero};
    endfunction

endpackage

// File: rtl/zap_mult_limb.sv
// Combinational (LIMB_W+1)x(LIMB_W+1) signed multiplier; models the hard macro.
module zap_mult_limb #(
    parameter int LIMB_W = 16
) (
    input  logic signed [LIMB_W:0]     i_a,
    input  logic signed [LIMB_W:0]     i_b,
    output logic signed [2*LIMB_W+1:0] o_p
);

    logic signed [2*LIMB_W+1:0] a_ext;
    logic signed [2*LIMB_W+1:0] b_ext;

    assign a_ext = {{(LIMB_W+1){i_a[LIMB_W]}}, i_a};
    assign b_ext = {{(LIMB_W+1){i_b[LIMB_W]}}, i_b};
    assign o_p   = a_ext * b_ext;

endmodule

// File: rtl/zap_mult_seq.sv
// Sequential multiply-accumulate: rm*rs + {rh,rn}, one limb pair per cycle.
// Define ZAP_MULT_EARLY_TERM_EN to skip rows whose rs limb is zero.
module zap_mult_seq
    import zap_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LIMB_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_stall,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_signed,
    input  logic                  i_long,
    input  logic                  i_acc,
    input  logic [DATA_W-1:0]     i_rm,
    input  logic [DATA_W-1:0]     i_rs,
    input  logic [DATA_W-1:0]     i_rh,
    input  logic [DATA_W-1:0]     i_rn,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*DATA_W-1:0]   o_result,
    output logic                  o_n,
    output logic                  o_z,
    output logic [1:0]            o_dbg_state
);

    localparam int L     = limb_count(DATA_W, LIMB_W);
    localparam int CW    = (L > 1) ? $clog2(L) : 1;
    localparam int RES_W = 2 * DATA_W;
    localparam int PP_W  = 2 * LIMB_W + 2;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rm_q, rm_d, rs_q, rs_d, rh_q, rh_d, rn_q, rn_d;
    logic                signed_q, signed_d, long_q, long_d, acc_q, acc_d;
    logic [CW-1:0]       i_q, i_d, j_q, j_d;
    logic [RES_W-1:0]    accum_q, accum_d, result_q, result_d;
    logic                valid_q, valid_d, n_q, n_d, z_q, z_d;

    logic [LIMB_W-1:0]        a_raw, b_raw;
    logic signed [LIMB_W:0]   a_ext, b_ext;
    logic signed [PP_W-1:0]   pp;
    logic signed [RES_W-1:0]  pp_ext;
    logic [RES_W-1:0]         pp_shift, sum, sel;
    logic [1:0]               flags;
    logic [CW-1:0]            first_row, next_row;
    logic                     has_next;

    zap_mult_limb #(.LIMB_W(LIMB_W)) u_limb (
        .i_a (a_ext),
        .i_b (b_ext),
        .o_p (pp)
    );

    // Only the top limb of each operand carries the sign; lower limbs are magnitudes.
    always_comb begin
        a_raw    = rm_q[i_q*LIMB_W +: LIMB_W];
        b_raw    = rs_q[j_q*LIMB_W +: LIMB_W];
        a_ext    = {signed_q & (i_q == CW'(L-1)) & a_raw[LIMB_W-1], a_raw};
        b_ext    = {signed_q & (j_q == CW'(L-1)) & b_raw[LIMB_W-1], b_raw};
        pp_ext   = RES_W'(pp);
        pp_shift = pp_ext << ((int'(i_q) + int'(j_q)) * LIMB_W);
        sum      = accum_q + (acc_q ? {rh_q, rn_q} : {RES_W{1'b0}});
        sel      = long_q ? sum : {{DATA_W{1'b0}}, sum[DATA_W-1:0]};
        flags    = mult_flags(FLAG_MAX_W'(sel), long_q ? RES_W : DATA_W);
    end

`ifdef ZAP_MULT_EARLY_TERM_EN
    logic [L-1:0] nz_in, nz_q;

    // Rows are walked lowest-first, so each search keeps the smallest qualifying index.
    always_comb begin
        first_row = '0;
        next_row  = '0;
        has_next  = 1'b0;
        for (int k = 0; k < L; k++) begin
            nz_in[k] = |i_rs[k*LIMB_W +: LIMB_W];
            nz_q[k]  = |rs_q[k*LIMB_W +: LIMB_W];
        end
        for (int k = L - 1; k >= 0; k--) begin
            if (nz_in[k]) first_row = CW'(k);
            if (nz_q[k] && k > int'(j_q)) begin
                next_row = CW'(k);
                has_next = 1'b1;
            end
        end
    end
`else
    always_comb begin
        first_row = '0;
        next_row  = j_q + 1'b1;
        has_next  = (j_q != CW'(L-1));
    end
`endif

    always_comb begin
        state_d  = state_q;
        rm_d     = rm_q;
        rs_d     = rs_q;
        rh_d     = rh_q;
        rn_d     = rn_q;
        signed_d = signed_q;
        long_d   = long_q;
        acc_d    = acc_q;
        i_d      = i_q;
        j_d      = j_q;
        accum_d  = accum_q;
        result_d = result_q;
        valid_d  = valid_q;
        n_d      = n_q;
        z_d      = z_q;
        if (i_clear) begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            accum_d  = '0;
            result_d = '0;
            n_d      = 1'b0;
            z_d      = 1'b0;
        end else if (!i_stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        rm_d     = i_rm;
                        rs_d     = i_rs;
                        rh_d     = i_rh;
                        rn_d     = i_rn;
                        signed_d = i_signed;
                        long_d   = i_long;
                        acc_d    = i_acc;
                        accum_d  = '0;
                        i_d      = '0;
                        j_d      = first_row;
                        state_d  = ST_MUL;
                    end
                end
                ST_MUL: begin
                    accum_d = accum_q + pp_shift;
                    if (i_q == CW'(L-1)) begin
                        i_d = '0;
                        if (has_next) j_d = next_row;
                        else          state_d = ST_ACC;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                ST_ACC: begin
                    result_d = sel;
                    n_d      = flags[1];
                    z_d      = flags[0];
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            rm_q     <= '0;
            rs_q     <= '0;
            rh_q     <= '0;
            rn_q     <= '0;
            signed_q <= 1'b0;
            long_q   <= 1'b0;
            acc_q    <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            accum_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rm_q     <= rm_d;
            rs_q     <= rs_d;
            rh_q     <= rh_d;
            rn_q     <= rn_d;
            signed_q <= signed_d;
            long_q   <= long_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            j_q      <= j_d;
            accum_q  <= accum_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    // Handshake: a request transfers on a rising edge with i_valid & o_ready high;
    // a result transfers on a rising edge with o_valid & i_ready high and i_stall low.
    assign o_ready     = (state_q == ST_IDLE) & ~i_stall;
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_n         = n_q;
    assign o_z         = z_q;
    assign o_dbg_state = state_q;

endmodule
